nbit_piso_serializer: RTL and testbench

Parameterised parallel-in, serial-out transmitter. It accepts an N-bit word over a valid/ready load handshake and shifts it out one bit per clock. It is the transmit end of the team's N-bit serial-in/parallel-out shift register link. With MSB_FIRST=1 its output stream fed into that receiver reproduces the loaded word in the receiver's shift stage. It sits between a word-producing block and a 1-bit serial wire.

---
 rtl/nbit_piso_serializer_pkg.sv | 16 +
 rtl/nbit_piso_serializer.sv | 87 ++++++++
 tb/tb_nbit_piso_serializer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/nbit_piso_serializer_pkg.sv
// Shared types and helpers for the N-bit parallel-in/serial-out transmitter.
// Holds the IDLE/SHIFT state encoding and the transmit-order bit-select helper.
package nbit_piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  // Index of the bit that leaves the shift register next.
  // MSB-first streams read the top bit; LSB-first streams read bit 0.
  function automatic int unsigned head_idx(input int unsigned n, input bit msb_first);
    return msb_first ? (n - 1) : 0;
  endfunction

endpackage

// File: rtl/nbit_piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts an N-bit word on a valid/ready
// handshake and streams it one bit per clock, with back-to-back word support.
module nbit_piso_serializer
  import nbit_piso_serializer_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         out,
  output logic         out_valid,
  output logic         last,
  output logic         busy
);

  localparam int unsigned    CW       = $clog2(N);
  localparam int unsigned    HEAD     = head_idx(N, MSB_FIRST);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(N - 1);

  piso_state_e   state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  logic          accept;
  logic [N-1:0]  sr_shift;

  // Shift toward the head position; the vacated end fills with zero.
  always_comb begin
    if (MSB_FIRST) sr_shift = {sr_q[N-2:0], 1'b0};
    else           sr_shift = {1'b0, sr_q[N-1:1]};
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    load_ready = (state_q == ST_IDLE) || (cnt_q == '0);
    accept     = load_valid && load_ready;

    if (accept) begin
      // First bit goes straight to out, so the word streams with no bubble.
      state_d = ST_SHIFT;
      sr_d    = din;
      cnt_d   = CNT_LOAD;
      out_d   = din[HEAD];
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q != '0) begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - 1'b1;
        out_d = sr_shift[HEAD];
      end else begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out       = out_q;
  assign busy      = (state_q == ST_SHIFT);
  assign out_valid = busy;
  assign last      = busy && (cnt_q == '0);

endmodule

// File: tb/tb_nbit_piso_serializer.sv
// Directed self-checking bench for nbit_piso_serializer: MSB-first and
// LSB-first instances, with a 4-bit serial-in receiver on the MSB-first stream.
module tb_nbit_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       lv_m, lv_l;
  logic       ready_m, out_m, ov_m, last_m, busy_m;
  logic       ready_l, out_l, ov_l, last_l, busy_l;
  logic [3:0] rx_sr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nbit_piso_serializer #(.N(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(lv_m), .load_ready(ready_m),
    .out(out_m), .out_valid(ov_m), .last(last_m), .busy(busy_m)
  );

  nbit_piso_serializer #(.N(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(lv_l), .load_ready(ready_l),
    .out(out_l), .out_valid(ov_l), .last(last_l), .busy(busy_l)
  );

  // Serial-in/parallel-out receiver: shifts in at bit 0 while out_valid is high.
  always @(posedge clk) begin
    if (rst)       rx_sr <= 4'b0000;
    else if (ov_m) rx_sr <= {rx_sr[2:0], out_m};
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stream;
  logic [3:0] word;

  initial begin
    rst  = 1'b1;
    din  = 4'hF;
    lv_m = 1'b1;
    lv_l = 1'b1;

    // Reset held two cycles with a pending load: nothing may be accepted.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out",  {7'd0, out_m},  8'd0);
      chk("rst_ov",   {7'd0, ov_m},   8'd0);
      chk("rst_busy", {7'd0, busy_m}, 8'd0);
      chk("rst_last", {7'd0, last_m}, 8'd0);
      chk("rst_busy_l", {7'd0, busy_l}, 8'd0);
    end
    rst  = 1'b0;
    lv_m = 1'b0;
    lv_l = 1'b0;
    chk("rst_ready", {7'd0, ready_m}, 8'd1);
    tick();
    chk("post_rst_busy", {7'd0, busy_m}, 8'd0);

    // Single MSB-first word 1011.
    word = 4'b1011;
    din  = word;
    lv_m = 1'b1;
    tick();
    lv_m = 1'b0;
    din  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      chk("single_out",  {7'd0, out_m},  {7'd0, word[3-i]});
      chk("single_ov",   {7'd0, ov_m},   8'd1);
      chk("single_last", {7'd0, last_m}, {7'd0, (i == 3)});
      tick();
    end
    chk("single_idle_out",  {7'd0, out_m},  8'd0);
    chk("single_idle_busy", {7'd0, busy_m}, 8'd0);

    // Back-to-back: 1011 then 0110 with load_valid held high.
    stream = 8'b1011_0110;
    din    = 4'b1011;
    lv_m   = 1'b1;
    tick();
    din = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_out",   {7'd0, out_m},   {7'd0, stream[7-i]});
      chk("b2b_ov",    {7'd0, ov_m},    8'd1);
      chk("b2b_ready", {7'd0, ready_m}, {7'd0, (i == 3 || i == 7)});
      if (i == 7) lv_m = 1'b0;
      tick();
    end
    chk("b2b_idle_busy", {7'd0, busy_m}, 8'd0);

    // Stall: a load offered during bit 2 waits until the last bit of 1011.
    word = 4'b1011;
    din  = word;
    lv_m = 1'b1;
    tick();
    lv_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        din  = 4'b0001;
        lv_m = 1'b1;
        chk("stall_ready_lo", {7'd0, ready_m}, 8'd0);
      end
      if (i == 3) chk("stall_ready_hi", {7'd0, ready_m}, 8'd1);
      chk("stall_inflight", {7'd0, out_m}, {7'd0, word[3-i]});
      tick();
    end
    lv_m = 1'b0;
    word = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk("stall_next", {7'd0, out_m}, {7'd0, word[3-i]});
      chk("stall_next_last", {7'd0, last_m}, {7'd0, (i == 3)});
      tick();
    end
    chk("stall_idle_busy", {7'd0, busy_m}, 8'd0);

    // Reset mid-word (during bit 2 of 1111), coinciding with a load attempt.
    din  = 4'b1111;
    lv_m = 1'b1;
    tick();
    lv_m = 1'b0;
    tick();
    tick();
    chk("mid_bit2", {7'd0, out_m}, 8'd1);
    rst  = 1'b1;
    lv_m = 1'b1;
    tick();
    chk("mid_rst_out",  {7'd0, out_m},  8'd0);
    chk("mid_rst_ov",   {7'd0, ov_m},   8'd0);
    chk("mid_rst_busy", {7'd0, busy_m}, 8'd0);
    chk("mid_rst_last", {7'd0, last_m}, 8'd0);
    rst  = 1'b0;
    lv_m = 1'b0;

    // Clean restart after reset, looped back into the receiver.
    word = 4'b1101;
    din  = word;
    lv_m = 1'b1;
    tick();
    lv_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("loop_out", {7'd0, out_m}, {7'd0, word[3-i]});
      tick();
    end
    chk("loop_rx", {4'd0, rx_sr}, 8'h0D);
    chk("loop_idle_busy", {7'd0, busy_m}, 8'd0);

    // LSB-first instance: 1101 streams as 1,0,1,1.
    word = 4'b1101;
    din  = word;
    lv_l = 1'b1;
    tick();
    lv_l = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lsb_out",  {7'd0, out_l},  {7'd0, word[i]});
      chk("lsb_last", {7'd0, last_l}, {7'd0, (i == 3)});
      tick();
    end
    chk("lsb_idle_out",  {7'd0, out_l},  8'd0);
    chk("lsb_idle_busy", {7'd0, busy_l}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
